if_id_elastic_stage: RTL

Parametrised, elastic successor to the fixed IF/ID pipeline register. It sits between fetch and decode and carries an instruction word and its PC. It replaces the bare enable/reset pair with a valid/ready handshake and a two-entry skid buffer, so back-pressure does not need a combinational ready path. A synchronous flush discards in-flight entries on branch mispredict, and optional saturating performance counters can be compiled in.

---
 rtl/pipe_stage_pkg.sv | 17 +
 rtl/pipe_stage_sat_cnt.sv | 27 ++
 rtl/if_id_elastic_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
// Shared definitions for the elastic IF/ID stage: state encoding of the
// occupancy FSM and the MIPS no-op word driven when decode sees no entry.
// No ports.

package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_sat_cnt.sv
// pipe_stage_sat_cnt
// Saturating up-counter used for the optional stage performance counters.
// Holds at all-ones instead of wrapping; cleared only by reset.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high clear
//   inc    in   count this cycle
//   count  out  CNT_W-bit current value

module pipe_stage_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_elastic_stage.sv
// if_id_elastic_stage
// Elastic IF/ID pipeline stage: valid/ready on both sides with a two-entry
// skid buffer so in_ready is decoded from registered state only and never
// depends on out_ready in the same cycle. Synchronous flush drops everything
// in flight. Optional saturating performance counters are compiled in with
// the PIPE_STAGE_PERF_EN macro.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   flush                 synchronous mispredict flush
//   in_valid/in_ready     fetch-side handshake
//   in_instr, in_pc       entry from fetch
//   out_valid/out_ready   decode-side handshake
//   out_instr, out_pc     entry to decode (NOP_WORD / 0 when not valid)
//   stall_cycles          cycles with out_valid & !out_ready (macro only)
//   flush_drops           flushes that discarded a valid entry (macro only)
//
// state    | meaning
// ---------+-------------------------------------
// ST_EMPTY | nothing held
// ST_ONE   | main register holds the head entry
// ST_FULL  | main holds the head, skid the next one

module if_id_elastic_stage
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_drops
`endif
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              in_fire;
  logic              out_fire;

  // Both handshake qualifiers come straight from the state register.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Main may still hold a consumed entry after ONE -> EMPTY, so gate it here.
  assign out_instr = out_valid ? main_instr_q : NOP_WORD;
  assign out_pc    = out_valid ? main_pc_q    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_WORD;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      // An out_fire this cycle is still a completed transfer; only the
      // state update is overridden and the incoming entry is ignored.
      state_d      = ST_EMPTY;
      main_instr_d = NOP_WORD;
      main_pc_d    = '0;
      skid_instr_d = NOP_WORD;
      skid_pc_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              state_d      = ST_FULL;
              skid_instr_d = in_instr;
              skid_pc_d    = in_pc;
            end
            2'b01: state_d = ST_EMPTY;
            2'b11: begin
              main_instr_d = in_instr;
              main_pc_d    = in_pc;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d      = ST_ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cycles)
  );

  pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush & (state_q != ST_EMPTY)),
    .count (flush_drops)
  );
`endif

endmodule
